// File: rtl/mem_cmd_controller_if.sv
// UART-side byte handshake between the receiver/transmitter and mem_cmd_controller.
// Slave modport is the controller; master modport is the UART (or its model).
interface mem_cmd_controller_if;
    logic       received;
    logic [7:0] rx_byte;
    logic       recv_error;
    logic       is_transmitting;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       busy;

    modport master (
        output received, rx_byte, recv_error, is_transmitting,
        input  transmit, tx_byte, busy
    );

    modport slave (
        input  received, rx_byte, recv_error, is_transmitting,
        output transmit, tx_byte, busy
    );
endinterface

// File: rtl/mem_cmd_controller.sv
// UART byte-command RAM controller (W/R/B commands); idle-parse timeout under MEM_CMD_TIMEOUT_EN.
// Latency: read reply 3 cycles after address byte, write ack 2 cycles after data byte.
// Backpressure: waits on is_transmitting per reply byte; bytes arriving outside parse states are dropped.
module mem_cmd_controller #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input logic                 clk,
    input logic                 rst,
    mem_cmd_controller_if.slave bus
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_GET_ADDR = 4'd1;
    localparam logic [3:0] S_GET_DATA = 4'd2;
    localparam logic [3:0] S_GET_LEN  = 4'd3;
    localparam logic [3:0] S_RD_ISSUE = 4'd4;
    localparam logic [3:0] S_RD_WAIT  = 4'd5;
    localparam logic [3:0] S_SEND     = 4'd6;
    localparam logic [3:0] S_TX_START = 4'd7;
    localparam logic [3:0] S_TX_DONE  = 4'd8;
    localparam logic [3:0] S_WRITE    = 4'd9;

    localparam logic [1:0] CMD_WR    = 2'd0;
    localparam logic [1:0] CMD_RD    = 2'd1;
    localparam logic [1:0] CMD_BURST = 2'd2;

    generate
        if (ADDR_WIDTH < 1 || ADDR_WIDTH > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
            $error("mem_cmd_controller: illegal ADDR_WIDTH or TIMEOUT_CYCLES");
        end
    endgenerate

    logic [3:0]            state;
    logic [1:0]            cmd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            wdat_q;
    logic [8:0]            burst_cnt;
    logic [7:0]            tx_byte_q;
    logic [7:0]            rd_dat;
    logic [7:0]            mem [2**ADDR_WIDTH];
    logic                  parse_state;
    logic                  timeout_hit;

    assign parse_state = (state == S_GET_ADDR) || (state == S_GET_DATA) || (state == S_GET_LEN);

`ifdef MEM_CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0] to_cnt;

    // Counter sits at zero outside the parse states, so entering one starts a fresh window.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (!parse_state || bus.received) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = parse_state && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cmd_q     <= CMD_WR;
            addr_q    <= '0;
            wdat_q    <= 8'h00;
            burst_cnt <= 9'd0;
            tx_byte_q <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.received) begin
                        case (bus.rx_byte)
                            8'h57: begin cmd_q <= CMD_WR;    state <= S_GET_ADDR; end
                            8'h52: begin cmd_q <= CMD_RD;    state <= S_GET_ADDR; end
                            8'h42: begin cmd_q <= CMD_BURST; state <= S_GET_ADDR; end
                            default: begin
                                tx_byte_q <= 8'h3F;
                                state     <= S_SEND;
                            end
                        endcase
                    end
                end
                // In the parse states a same-cycle byte beats timer expiry; a framing error beats both.
                S_GET_ADDR: begin
                    if (bus.recv_error) begin
                        state <= S_IDLE;
                    end else if (bus.received) begin
                        addr_q <= bus.rx_byte[ADDR_WIDTH-1:0];
                        case (cmd_q)
                            CMD_WR:    state <= S_GET_DATA;
                            CMD_BURST: state <= S_GET_LEN;
                            default: begin
                                burst_cnt <= 9'd1;
                                state     <= S_RD_ISSUE;
                            end
                        endcase
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_GET_DATA: begin
                    if (bus.recv_error) begin
                        state <= S_IDLE;
                    end else if (bus.received) begin
                        wdat_q <= bus.rx_byte;
                        state  <= S_WRITE;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_GET_LEN: begin
                    if (bus.recv_error) begin
                        state <= S_IDLE;
                    end else if (bus.received) begin
                        burst_cnt <= (bus.rx_byte == 8'h00) ? 9'd256 : {1'b0, bus.rx_byte};
                        state     <= S_RD_ISSUE;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_RD_ISSUE: begin
                    addr_q    <= addr_q + 1'b1;
                    burst_cnt <= burst_cnt - 9'd1;
                    state     <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    tx_byte_q <= rd_dat;
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (!bus.is_transmitting) state <= S_TX_START;
                end
                S_TX_START: begin
                    if (bus.is_transmitting) state <= S_TX_DONE;
                end
                S_TX_DONE: begin
                    if (!bus.is_transmitting) state <= (burst_cnt != 9'd0) ? S_RD_ISSUE : S_IDLE;
                end
                S_WRITE: begin
                    tx_byte_q <= 8'h4B;
                    state     <= S_SEND;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM is deliberately outside the reset domain; contents survive rst.
    always_ff @(posedge clk) begin
        if (state == S_WRITE) mem[addr_q] <= wdat_q;
        if (state == S_RD_ISSUE) rd_dat <= mem[addr_q];
    end

    assign bus.transmit = (state == S_SEND) && !bus.is_transmitting;
    assign bus.tx_byte  = tx_byte_q;
    assign bus.busy     = (state != S_IDLE);

endmodule
